pulse_handshake_tx: RTL and testbench

- Multi-channel, send-side front end of a toggle req/ack pulse crossing; the next generation of the single-channel feedback synchronizer.
- Per channel, it accepts single-cycle event pulses in the in_clk domain and launches each one as a toggle on out_req. It waits for the returned ack toggle, which this block synchronizes, before launching the next.
- Unlike the single-channel block, back-to-back bursts can be queued in a saturating pending counter instead of dropped. Drops and saturation are flagged.

---
 rtl/cdc_pkg.sv | 13 +
 rtl/sync_2ff_bus.sv | 25 ++
 rtl/pulse_handshake_tx.sv | 83 ++++++++
 tb/tb_pulse_handshake_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the pulse-crossing blocks.
package cdc_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  localparam int MODE_DROP  = 0;
  localparam int MODE_QUEUE = 1;

  function automatic int max_pending(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/sync_2ff_bus.sv
// Multi-bit flop-chain synchronizer; each bit is an independent single-bit crossing.
module sync_2ff_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Send side of a multi-channel toggle req/ack pulse crossing with per-channel event backlog.
module pulse_handshake_tx
  import cdc_pkg::*;
#(
  parameter int CH          = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int QUEUE_EN    = MODE_QUEUE
) (
  input  logic                in_clk,
  input  logic                in_areset_n,
  input  logic [CH-1:0]       in_pulse,
  input  logic [CH-1:0]       in_ack,
  input  logic [CH-1:0]       in_clear_ovf,
  output logic [CH-1:0]       out_req,
  output logic [CH-1:0]       out_busy,
  output logic [CH-1:0]       out_overflow,
  output logic [CH*CNT_W-1:0] out_pending
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(max_pending(CNT_W));

  logic [CH-1:0] ack_s;

  sync_2ff_bus #(
    .WIDTH  (CH),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (in_clk),
    .rst_n (in_areset_n),
    .d     (in_ack),
    .q     (ack_s)
  );

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             req_q;
    logic             ovf_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             idle;
    logic             from_pend;
    logic             launch;
    logic             ovf_set;

    // A pulse landing on an idle, empty channel launches immediately and never touches the count.
    always_comb begin
      idle      = (req_q == ack_s[i]);
      from_pend = idle && (pend_q != '0);
      launch    = from_pend || (idle && in_pulse[i]);
      pend_d    = pend_q;
      ovf_set   = 1'b0;
      if (QUEUE_EN == MODE_QUEUE) begin
        if (in_pulse[i] && !idle) begin
          if (pend_q == PEND_MAX) ovf_set = 1'b1;
          else                    pend_d  = pend_q + CNT_W'(1);
        end else if (from_pend && !in_pulse[i]) begin
          pend_d = pend_q - CNT_W'(1);
        end
      end else begin
        pend_d  = '0;
        ovf_set = in_pulse[i] && !idle;
      end
    end

    always_ff @(posedge in_clk or negedge in_areset_n) begin
      if (!in_areset_n) begin
        req_q  <= 1'b0;
        ovf_q  <= 1'b0;
        pend_q <= '0;
      end else begin
        if (launch) req_q <= ~req_q;
        pend_q <= pend_d;
        ovf_q  <= ovf_set | (ovf_q & ~in_clear_ovf[i]);
      end
    end

    assign out_req[i]                     = req_q;
    assign out_overflow[i]                = ovf_q;
    assign out_pending[i*CNT_W +: CNT_W]  = pend_q;
    assign out_busy[i]                    = (req_q != ack_s[i]) || (pend_q != '0);
  end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Random and directed bench for pulse_handshake_tx: one queue-mode and one drop-mode instance.
module tb_pulse_handshake_tx;
  import cdc_pkg::*;

  localparam int CH    = 4;
  localparam int CNT_W = 3;
  localparam int SYNC  = 2;

  logic in_clk = 1'b0;
  logic in_areset_n = 1'b0;

  logic [CH-1:0]       pulse_q = '0, ack_q = '0, clr_q = '0;
  logic [CH-1:0]       req_q, busy_q, ovf_q;
  logic [CH*CNT_W-1:0] pend_q;
  logic [CH-1:0]       pulse_d = '0, ack_d = '0, clr_d = '0;
  logic [CH-1:0]       req_d, busy_d, ovf_d;
  logic [CH*CNT_W-1:0] pend_d;

  pulse_handshake_tx #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .QUEUE_EN(MODE_QUEUE)) dut_q (
    .in_clk(in_clk), .in_areset_n(in_areset_n), .in_pulse(pulse_q), .in_ack(ack_q),
    .in_clear_ovf(clr_q), .out_req(req_q), .out_busy(busy_q), .out_overflow(ovf_q),
    .out_pending(pend_q));

  pulse_handshake_tx #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .QUEUE_EN(MODE_DROP)) dut_d (
    .in_clk(in_clk), .in_areset_n(in_areset_n), .in_pulse(pulse_d), .in_ack(ack_d),
    .in_clear_ovf(clr_d), .out_req(req_d), .out_busy(busy_d), .out_overflow(ovf_d),
    .out_pending(pend_d));

  always #5 in_clk = ~in_clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference state: index 0 = queue-mode instance, 1 = drop-mode instance.
  int m_pend  [2][CH];
  int m_ready [2][CH];
  bit m_req   [2][CH];
  bit m_ovf   [2][CH];

  int next_lat [2][CH];
  int ack_due  [2][CH];
  bit seen_req [2][CH];
  int lat_lo = 3, lat_hi = 3;
  int toggles_q1 = 0;
  int peak_q1 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, actual, expected, edge_n);
    end
  endtask

  function automatic int drawLat();
    return $urandom_range(lat_hi, lat_lo);
  endfunction

  task automatic waitEdge();
    @(posedge in_clk);
    edge_n++;
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        m_pend[d][c] = 0; m_ready[d][c] = 0; m_req[d][c] = 0; m_ovf[d][c] = 0;
        ack_due[d][c] = -1; seen_req[d][c] = 0; next_lat[d][c] = drawLat();
      end
  endtask

  // Channel may launch at an edge once its last request's ack has had time to cross back.
  task automatic modelStep(input int d, input logic [CH-1:0] p, input logic [CH-1:0] clr);
    int mx;
    mx = max_pending(CNT_W);
    for (int c = 0; c < CH; c++) begin
      bit idle, launch, set;
      idle = (edge_n >= m_ready[d][c]);
      launch = 0; set = 0;
      if (d == 0) begin
        if (idle && m_pend[d][c] > 0) begin
          launch = 1;
          if (!p[c]) m_pend[d][c]--;
        end else if (idle && p[c]) launch = 1;
        else if (p[c]) begin
          if (m_pend[d][c] == mx) set = 1;
          else m_pend[d][c]++;
        end
      end else begin
        if (idle && p[c]) launch = 1;
        else if (p[c]) set = 1;
      end
      if (launch) begin
        m_req[d][c] = ~m_req[d][c];
        m_ready[d][c] = edge_n + next_lat[d][c] + SYNC;
      end
      if (set) m_ovf[d][c] = 1;
      else if (clr[c]) m_ovf[d][c] = 0;
    end
  endtask

  task automatic compareAll(input int d);
    logic [CH-1:0] e_req, e_busy, e_ovf;
    logic [CH*CNT_W-1:0] e_pend;
    string pfx;
    pfx = (d == 0) ? "queue" : "drop";
    for (int c = 0; c < CH; c++) begin
      e_req[c]  = m_req[d][c];
      e_ovf[c]  = m_ovf[d][c];
      e_busy[c] = (edge_n + 1 < m_ready[d][c]) || (m_pend[d][c] != 0);
      e_pend[c*CNT_W +: CNT_W] = CNT_W'(m_pend[d][c]);
    end
    checkOutput({pfx, ".req"},      (d == 0) ? req_q  : req_d,  e_req);
    checkOutput({pfx, ".busy"},     (d == 0) ? busy_q : busy_d, e_busy);
    checkOutput({pfx, ".overflow"}, (d == 0) ? ovf_q  : ovf_d,  e_ovf);
    checkOutput({pfx, ".pending"},  (d == 0) ? pend_q : pend_d, e_pend);
  endtask

  // Receiver stand-in: answers each observed req toggle with an ack toggle after a latency.
  task automatic receiverStep();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        logic r, a;
        r = (d == 0) ? req_q[c] : req_d[c];
        if (r != seen_req[d][c]) begin
          seen_req[d][c] = r;
          ack_due[d][c] = edge_n + next_lat[d][c];
          next_lat[d][c] = drawLat();
          if (d == 0 && c == 1) toggles_q1++;
        end
        if (ack_due[d][c] == edge_n + 1) begin
          a = (d == 0) ? ack_q[c] : ack_d[c];
          checkOutput("proto.ack_only_when_outstanding", a != r, 1);
          ack_due[d][c] = -1;
          if (d == 0) ack_q[c] = ~ack_q[c];
          else        ack_d[c] = ~ack_d[c];
        end
      end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] pq, input logic [CH-1:0] cq,
                               input logic [CH-1:0] pd, input logic [CH-1:0] cd);
    int p1;
    pulse_q = pq; clr_q = cq; pulse_d = pd; clr_d = cd;
    waitEdge();
    modelStep(0, pq, cq);
    modelStep(1, pd, cd);
    #1;
    compareAll(0);
    compareAll(1);
    p1 = int'(pend_q[1*CNT_W +: CNT_W]);
    if (p1 > peak_q1) peak_q1 = p1;
    receiverStep();
  endtask

  task automatic doReset();
    #3;
    in_areset_n = 1'b0;
    pulse_q = '0; clr_q = '0; pulse_d = '0; clr_d = '0;
    ack_q = '0; ack_d = '0;
    #1;
    checkOutput("reset.req",      {req_q, req_d},   '0);
    checkOutput("reset.busy",     {busy_q, busy_d}, '0);
    checkOutput("reset.overflow", {ovf_q, ovf_d},   '0);
    checkOutput("reset.pending",  {pend_q, pend_d}, '0);
    repeat (3) waitEdge();
    #1;
    resetModel();
    in_areset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [CH-1:0] rp, rc, rd, re;
    resetModel();
    doReset();

    // Idle after reset.
    repeat (50) applyStimulus('0, '0, '0, '0);

    // Single event on channel 0, fixed 3-cycle receiver.
    lat_lo = 3; lat_hi = 3; resetModelLat();
    applyStimulus(4'b0001, '0, 4'b0001, '0);
    checkOutput("single.req_toggle", req_q[0], 1'b1);
    cnt = 0;
    while (busy_q[0] && cnt < 20) begin
      applyStimulus('0, '0, '0, '0);
      cnt++;
    end
    checkOutput("single.busy_fall_edges", cnt, 4);
    repeat (5) applyStimulus('0, '0, '0, '0);

    // Burst of 7 behind an outstanding request on channel 1.
    lat_lo = 10; lat_hi = 10; resetModelLat();
    toggles_q1 = 0; peak_q1 = 0;
    applyStimulus(4'b0010, '0, '0, '0);
    repeat (7) applyStimulus(4'b0010, '0, '0, '0);
    repeat (110) applyStimulus('0, '0, '0, '0);
    checkOutput("burst.peak_pending", peak_q1, 7);
    checkOutput("burst.toggles", toggles_q1, 8);
    checkOutput("burst.overflow", ovf_q[1], 1'b0);

    // Saturation on channel 2, then set-wins and clear-alone.
    applyStimulus(4'b0100, '0, '0, '0);
    repeat (10) applyStimulus(4'b0100, '0, '0, '0);
    checkOutput("sat.pending_hold", pend_q[2*CNT_W +: CNT_W], 3'd7);
    checkOutput("sat.overflow_set", ovf_q[2], 1'b1);
    applyStimulus(4'b0100, 4'b0100, '0, '0);
    checkOutput("sat.set_wins", ovf_q[2], 1'b1);
    applyStimulus('0, 4'b0100, '0, '0);
    checkOutput("sat.clear_alone", ovf_q[2], 1'b0);
    repeat (100) applyStimulus('0, '0, '0, '0);

    // Drop-mode pattern, mirrored onto queue channel 3.
    lat_lo = 2; lat_hi = 3; resetModelLat();
    for (int t = 0; t < 100; t++) begin
      rp = ((t == 40) || (t == 42) || (t >= 75 && t <= 81)) ? 4'b1001 : 4'b0000;
      rc = (t == 60) ? 4'b1001 : 4'b0000;
      applyStimulus(rp & 4'b1000, rc & 4'b1000, rp & 4'b0001, rc & 4'b0001);
    end
    checkOutput("drop.overflow", ovf_d[0], 1'b1);
    checkOutput("drop.pending_zero", pend_d, '0);

    // Randomized traffic on all channels of both instances.
    lat_lo = 2; lat_hi = 6; resetModelLat();
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < CH; c++) begin
        rp[c] = ($urandom_range(3, 0) == 0);
        rd[c] = ($urandom_range(3, 0) == 0);
        rc[c] = ($urandom_range(15, 0) == 0);
        re[c] = ($urandom_range(15, 0) == 0);
      end
      applyStimulus(rp, rc, rd, re);
    end
    repeat (150) applyStimulus('0, 4'hf, '0, 4'hf);

    // Reset mid-burst with pending = 5 and a request outstanding.
    lat_lo = 10; lat_hi = 10; resetModelLat();
    applyStimulus(4'b0010, '0, '0, '0);
    repeat (5) applyStimulus(4'b0010, '0, '0, '0);
    checkOutput("midrst.pending_before", pend_q[1*CNT_W +: CNT_W], 3'd5);
    doReset();
    toggles_q1 = 0;
    repeat (30) applyStimulus('0, '0, '0, '0);
    checkOutput("midrst.no_toggles", toggles_q1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic resetModelLat();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) next_lat[d][c] = drawLat();
  endtask

endmodule
